// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, NOP encoding and fetch FSM states for the fetch unit.
package riscv_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int PC_WIDTH = 32;
  localparam int INST_WIDTH = 32;
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h00000013;
  typedef enum logic [1:0] {BOOT, FETCH, FLUSH} ifu_state_e;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: power-of-two circular fetch buffer with flush taking priority over push/pop.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr] <= din;
  end
  assign dout = mem[rd];
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: credit-limited instruction fetch with in-order response buffer and redirect flush.
// Define IFU_PERF_CNT_EN to add the saturating ifu_perf_stall_cnt output.
module ifu_fetch
  import riscv_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int BUF_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ifu_req_addr_vld,
  input  logic                  ifu_req_addr_rdy,
  output logic [ADDR_WIDTH-1:0] ifu_req_addr,
  input  logic                  ifu_rsp_data_vld,
  input  logic [DATA_WIDTH-1:0] ifu_rsp_data,
  output logic                  ifu_valid,
  input  logic                  ifu_ready,
  output logic [PC_WIDTH-1:0]   ifu_pc,
  output logic [INST_WIDTH-1:0] ifu_inst,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]           ifu_perf_stall_cnt,
`endif
  input  logic                  redirect_vld,
  input  logic [PC_WIDTH-1:0]   redirect_pc
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] MAX_O = (CW+1)'(MAX_OUTSTANDING);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);
  ifu_state_e state, state_n;
  logic [PC_WIDTH-1:0] fetch_pc, rsp_pc, target;
  logic [CW-1:0] outstanding, drop, drop_n, buf_count;
  logic accept, rsp_drop, push, pop, empty, full;
  logic [PC_WIDTH+DATA_WIDTH-1:0] head;
  assign target = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  // Credits cover both in-flight requests and buffered entries, so a push never finds the buffer full.
  assign ifu_req_addr_vld = state != BOOT && !redirect_vld && {1'b0, outstanding} < MAX_O &&
                            {1'b0, outstanding} + {1'b0, buf_count} < DEPTH_C;
  assign ifu_req_addr = ADDR_WIDTH'(fetch_pc);
  assign accept = ifu_req_addr_vld && ifu_req_addr_rdy;
  assign rsp_drop = ifu_rsp_data_vld && drop != '0;
  assign push = ifu_rsp_data_vld && drop == '0 && !redirect_vld;
  assign pop = ifu_valid && ifu_ready && !redirect_vld;
  assign ifu_valid = !empty;
  assign ifu_pc = empty ? '0 : head[PC_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign ifu_inst = empty ? NOP_INST : INST_WIDTH'(head[DATA_WIDTH-1:0]);
  always_comb begin
    drop_n = redirect_vld ? outstanding - CW'(ifu_rsp_data_vld) : drop - CW'(rsp_drop);
    state_n = state == BOOT ? FETCH : (drop_n != '0 ? FLUSH : FETCH);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(ifu_rsp_data_vld);
      drop <= drop_n;
      if (redirect_vld) begin
        fetch_pc <= target;
        rsp_pc <= target;
      end else begin
        if (accept) fetch_pc <= fetch_pc + PC_WIDTH'(4);
        if (push) rsp_pc <= rsp_pc + PC_WIDTH'(4);
      end
    end
  end
  ifu_fifo #(.WIDTH(PC_WIDTH + DATA_WIDTH), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_vld),
    .din   ({rsp_pc, ifu_rsp_data}),
    .dout  (head),
    .count (buf_count),
    .empty (empty),
    .full  (full)
  );
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ifu_perf_stall_cnt <= '0;
    else if (state != BOOT && !ifu_valid && ifu_perf_stall_cnt != '1) ifu_perf_stall_cnt <= ifu_perf_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed checks of fetch order, backpressure, redirect/drop, wrap and reset.
module tb_ifu_fetch;
  import riscv_pkg::*;
  logic clk = 0, rst_n = 0, rdy = 0, rsp_vld = 0, ready = 0, redir = 0;
  logic [31:0] rsp_data = 0, redir_pc = 0;
  logic req_vld, valid;
  logic [31:0] req_addr, pc, inst;
  int tests = 0, fails = 0;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif
  ifu_fetch #(.RESET_PC(32'h100), .BUF_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ifu_req_addr_vld (req_vld),
    .ifu_req_addr_rdy (rdy),
    .ifu_req_addr     (req_addr),
    .ifu_rsp_data_vld (rsp_vld),
    .ifu_rsp_data     (rsp_data),
    .ifu_valid        (valid),
    .ifu_ready        (ready),
    .ifu_pc           (pc),
    .ifu_inst         (inst),
`ifdef IFU_PERF_CNT_EN
    .ifu_perf_stall_cnt (stall_cnt),
`endif
    .redirect_vld     (redir),
    .redirect_pc      (redir_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] d(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 0; rdy = 0; rsp_vld = 0; ready = 0; redir = 0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_req_vld", req_vld, 0);
    chk("rst_pc", pc, 0);
    chk("rst_inst", inst, 32'h13);
    nxt;
    rst_n = 1;
    #1;
    chk("boot_req_vld", req_vld, 0);
  endtask
  initial begin
    int acc;
    logic pend;
    logic [31:0] pa;
    // in-order fetch from RESET_PC with one-cycle responses
    do_reset;
    nxt;
    rdy = 1; #1;
    chk("s1_vld0", req_vld, 1);
    chk("s1_addr0", req_addr, 32'h100);
    nxt;
    rsp_vld = 1; rsp_data = d(32'h100); #1;
    chk("s1_addr1", req_addr, 32'h104);
    nxt;
    rsp_data = d(32'h104); #1;
    chk("s1_valid", valid, 1);
    chk("s1_pc0", pc, 32'h100);
    chk("s1_inst0", inst, d(32'h100));
    chk("s1_addr2", req_addr, 32'h108);
    nxt;
    rdy = 0; rsp_vld = 0; ready = 1; #1;
    chk("s1_pc0_hold", pc, 32'h100);
    nxt;
    rsp_vld = 1; rsp_data = d(32'h108); #1;
    chk("s1_pc1", pc, 32'h104);
    chk("s1_inst1", inst, d(32'h104));
    nxt;
    rsp_vld = 0; #1;
    chk("s1_pc2", pc, 32'h108);
    chk("s1_inst2", inst, d(32'h108));
    nxt;
    ready = 0; #1;
    chk("s1_empty_valid", valid, 0);
    chk("s1_empty_pc", pc, 0);
    chk("s1_empty_inst", inst, 32'h13);
    chk("s1_addr3", req_addr, 32'h10C);
    // backpressure: decode stalled, buffer credit limits requests to four
    do_reset;
    nxt;
    rdy = 1; acc = 0; pend = 0; pa = 0;
    for (int i = 0; i < 6; i++) begin
      rsp_vld = pend; rsp_data = d(pa); #1;
      pend = req_vld && rdy;
      if (pend) begin
        pa = req_addr;
        acc++;
      end
      nxt;
    end
    rsp_vld = 0; #1;
    chk("s2_accepted", acc, 4);
    chk("s2_vld_blocked", req_vld, 0);
    chk("s2_head_pc", pc, 32'h100);
    ready = 1;
    nxt;
    ready = 0; #1;
    chk("s2_vld_after_pop", req_vld, 1);
    chk("s2_addr_after_pop", req_addr, 32'h110);
    nxt;
    rsp_vld = 1; rsp_data = d(32'h110); #1;
    chk("s2_vld_one_only", req_vld, 0);
    nxt;
    rsp_vld = 0; #1;
    chk("s2_vld_full", req_vld, 0);
    // redirect with two outstanding requests; reset also hits a full buffer here
    do_reset;
    nxt;
    rdy = 1; #1;
    chk("s3_addr0", req_addr, 32'h100);
    nxt;
    chk("s3_addr1", req_addr, 32'h104);
    nxt;
    redir = 1; redir_pc = 32'h2002; #1;
    chk("s3_vld_redir", req_vld, 0);
    nxt;
    redir = 0; rsp_vld = 1; rsp_data = 32'hBAD00100; #1;
    chk("s3_vld_flush", req_vld, 0);
    nxt;
    rsp_data = 32'hBAD00104; #1;
    chk("s3_valid_drop", valid, 0);
    chk("s3_vld_new", req_vld, 1);
    chk("s3_addr_new", req_addr, 32'h2000);
    nxt;
    rdy = 0; rsp_data = d(32'h2000); #1;
    chk("s3_valid_drop2", valid, 0);
    nxt;
    rsp_vld = 0; #1;
    chk("s3_valid", valid, 1);
    chk("s3_pc", pc, 32'h2000);
    chk("s3_inst", inst, d(32'h2000));
    // redirect together with a response and a pop
    do_reset;
    nxt;
    rdy = 1; #1;
    chk("s4_addr0", req_addr, 32'h100);
    nxt;
    rsp_vld = 1; rsp_data = d(32'h100);
    nxt;
    rsp_vld = 0; #1;
    chk("s4_pc_pre", pc, 32'h100);
    chk("s4_addr2", req_addr, 32'h108);
    nxt;
    redir = 1; redir_pc = 32'h3000; rsp_vld = 1; rsp_data = d(32'h104); ready = 1; #1;
    chk("s4_vld_redir", req_vld, 0);
    chk("s4_pc_redir", pc, 32'h100);
    nxt;
    redir = 0; rdy = 0; rsp_data = 32'hBAD00108; #1;
    chk("s4_valid_after", valid, 0);
    chk("s4_pc_after", pc, 0);
    chk("s4_inst_after", inst, 32'h13);
    chk("s4_addr_new", req_addr, 32'h3000);
    nxt;
    rsp_vld = 0; rdy = 1; #1;
    chk("s4_valid_dropped", valid, 0);
    chk("s4_addr_stable", req_addr, 32'h3000);
    nxt;
    rdy = 0; rsp_vld = 1; rsp_data = d(32'h3000);
    nxt;
    rsp_vld = 0; #1;
    chk("s4_valid_new", valid, 1);
    chk("s4_pc_new", pc, 32'h3000);
    chk("s4_inst_new", inst, d(32'h3000));
    // PC wrap at the top of the address space
    do_reset;
    nxt;
    redir = 1; redir_pc = 32'hFFFFFFFC; #1;
    chk("s5_vld_redir", req_vld, 0);
    nxt;
    redir = 0; rdy = 1; #1;
    chk("s5_addr_top", req_addr, 32'hFFFFFFFC);
    nxt;
    rsp_vld = 1; rsp_data = d(32'hFFFFFFFC); #1;
    chk("s5_addr_wrap", req_addr, 32'h0);
    nxt;
    rdy = 0; rsp_data = d(32'h0); ready = 1; #1;
    chk("s5_pc_top", pc, 32'hFFFFFFFC);
    nxt;
    rsp_vld = 0; #1;
    chk("s5_pc_wrap", pc, 32'h0);
    chk("s5_inst_wrap", inst, d(32'h0));
`ifdef IFU_PERF_CNT_EN
    do_reset;
    chk("perf_reset", stall_cnt, 0);
    repeat (11) nxt;
    chk("perf_stall10", stall_cnt, 10);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
